// File: rtl/rx_pkg.sv
// Shared types and constants for the serial frame receiver.
// The RX_PARITY_EN build option is handled in receiver_unit.
package rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic LINE_IDLE = 1'b1;

  // Offset from the start edge to the mid-bit sample point.
  function automatic int half_bit(input int clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Bit timer: fires a sample strobe H cycles after the start edge,
// then every CLKS_PER_BIT cycles until the next clear.
module rx_bit_timer
  import rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic arst,
  input  logic clear,
  output logic strobe
);

  localparam int H  = half_bit(CLKS_PER_BIT);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);
  // With H = 0 the start check happens on the start edge itself, so the
  // first strobe after clear is already the first data bit.
  localparam logic [CW-1:0] FIRST  = (H == 0) ? RELOAD : CW'(H - 1);

  logic [CW-1:0] cnt;

  assign strobe = (cnt == '0);

  always_ff @(posedge clk or negedge arst) begin
    if (!arst)       cnt <= '0;
    else if (clear)  cnt <= FIRST;
    else if (strobe) cnt <= RELOAD;
    else             cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/receiver_unit.sv
// Serial frame receiver: start detect, LSB-first data, stop check, held-valid output.
// Define RX_PARITY_EN to add an even-parity bit between data and stop.
module receiver_unit
  import rx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  rx_in,
  input  logic                  read_ack,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  output_ready,
  output logic                  frame_error,
  output logic                  parity_error,
  output logic                  overrun,
  output logic                  busy
);

  localparam int H  = half_bit(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);

  rx_state_e             state, state_n;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  strobe, clear, stop_smp, par_err, good;

  rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk    (clk),
    .arst   (arst),
    .clear  (clear),
    .strobe (strobe)
  );

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    clear   = 1'b0;
    case (state)
      IDLE: if (rx_in == START_BIT) begin
        clear   = 1'b1;
        state_n = (H == 0) ? DATA : START;
      end
      START: if (strobe) state_n = (rx_in == START_BIT) ? DATA : IDLE;
`ifdef RX_PARITY_EN
      DATA:   if (strobe && bit_cnt == LAST) state_n = PARITY;
      PARITY: if (strobe) state_n = STOP;
`else
      DATA:   if (strobe && bit_cnt == LAST) state_n = STOP;
`endif
      STOP:  if (strobe) state_n = (rx_in == STOP_BIT) ? IDLE : BREAK;
      // Hold off until the line returns high so a long low is not a new start.
      BREAK: if (rx_in == LINE_IDLE) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

`ifdef RX_PARITY_EN
  logic par_bit;
  always_ff @(posedge clk or negedge arst) begin
    if (!arst)                         par_bit <= 1'b0;
    else if (state == PARITY && strobe) par_bit <= rx_in;
  end
  assign par_err = par_bit ^ (^shreg);
`else
  assign par_err = 1'b0;
`endif

  assign stop_smp = (state == STOP) && strobe;
  assign good     = stop_smp && (rx_in == STOP_BIT) && !par_err;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      bit_cnt      <= '0;
      shreg        <= '0;
      data_out     <= '0;
      output_ready <= 1'b0;
      frame_error  <= 1'b0;
      parity_error <= 1'b0;
      overrun      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      busy         <= (state_n != IDLE);
      frame_error  <= stop_smp && (rx_in != STOP_BIT);
      parity_error <= stop_smp && par_err;

      if (clear)
        bit_cnt <= '0;
      else if (state == DATA && strobe && bit_cnt != LAST)
        bit_cnt <= bit_cnt + 1'b1;

      if (state == DATA && strobe)
        shreg <= {rx_in, shreg[DATA_WIDTH-1:1]};

      // A read_ack on the completing edge frees the slot for the new word.
      if (good) begin
        if (!output_ready || read_ack) begin
          data_out     <= shreg;
          output_ready <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (read_ack) begin
        output_ready <= 1'b0;
      end

      if (read_ack && output_ready)
        overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_receiver_unit.sv
// Scoreboard bench for receiver_unit: two instances (1 and 4 clocks per bit),
// stimulus pushes expected events, a negedge monitor pops and compares.
module tb_receiver_unit;

  localparam int DW = 8;
`ifdef RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk = 1'b0;
  logic arst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   sel = 0;
  logic rx_in = 1'b1;
  logic read_ack = 1'b0;

  logic rx0, rx1, ack0, ack1;
  assign rx0  = (sel == 0) ? rx_in : 1'b1;
  assign rx1  = (sel == 1) ? rx_in : 1'b1;
  assign ack0 = (sel == 0) ? read_ack : 1'b0;
  assign ack1 = (sel == 1) ? read_ack : 1'b0;

  logic [DW-1:0] d0, d1;
  logic rdy0, rdy1, fe0, fe1, pe0, pe1, ov0, ov1, bz0, bz1;

  receiver_unit #(.DATA_WIDTH(DW), .CLKS_PER_BIT(1)) u_n1 (
    .clk(clk), .arst(arst), .rx_in(rx0), .read_ack(ack0),
    .data_out(d0), .output_ready(rdy0), .frame_error(fe0),
    .parity_error(pe0), .overrun(ov0), .busy(bz0)
  );

  receiver_unit #(.DATA_WIDTH(DW), .CLKS_PER_BIT(4)) u_n4 (
    .clk(clk), .arst(arst), .rx_in(rx1), .read_ack(ack1),
    .data_out(d1), .output_ready(rdy1), .frame_error(fe1),
    .parity_error(pe1), .overrun(ov1), .busy(bz1)
  );

  logic [DW-1:0] m_d;
  logic m_rdy, m_fe, m_pe, m_ov, m_bz;
  assign m_d   = (sel == 0) ? d0   : d1;
  assign m_rdy = (sel == 0) ? rdy0 : rdy1;
  assign m_fe  = (sel == 0) ? fe0  : fe1;
  assign m_pe  = (sel == 0) ? pe0  : pe1;
  assign m_ov  = (sel == 0) ? ov0  : ov1;
  assign m_bz  = (sel == 0) ? bz0  : bz1;

  typedef enum int {EV_WORD, EV_FERR, EV_PERR} ev_e;
  typedef struct {
    ev_e           kind;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_check(input ev_e kind, input logic [DW-1:0] data);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got kind %0d data %0h at cycle %0d, expected none",
               kind, data, cyc);
    end else begin
      e = sbq.pop_front();
      if (e.kind != kind || e.data !== data || e.cyc != cyc) begin
        failures++;
        $display("FAIL event: got kind %0d data %0h cycle %0d, expected kind %0d data %0h cycle %0d",
                 kind, data, cyc, e.kind, e.data, e.cyc);
      end
    end
  endtask

  // A new word is on the output when ready rises, or stays high across an ack.
  logic prev_rdy = 1'b0;
  logic prev_ack = 1'b0;
  always @(negedge clk) begin
    if (m_rdy && (!prev_rdy || prev_ack)) pop_check(EV_WORD, m_d);
    if (m_fe) pop_check(EV_FERR, '0);
    if (m_pe) pop_check(EV_PERR, '0);
    prev_rdy = m_rdy;
    prev_ack = read_ack;
  end

  function automatic int nsel();
    return (sel == 0) ? 1 : 4;
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    cycles(n);
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    cycles(nsel());
  endtask

  task automatic ack();
    read_ack = 1'b1;
    cycles(1);
    read_ack = 1'b0;
  endtask

  task automatic push(input ev_e kind, input logic [DW-1:0] data, input int c);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.cyc  = c;
    sbq.push_back(e);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic stop_b, input int extra_low,
                      input logic bad_par, input logic ack_at_stop,
                      input logic p_word, input logic p_ferr, input logic p_perr);
    int n, h, t0, te;
    n  = nsel();
    h  = (n - 1) / 2;
    t0 = cyc + 1;
    te = t0 + h + (DW + 1 + P) * n;
    if (p_word) push(EV_WORD, d, te);
    if (p_ferr) push(EV_FERR, '0, te);
    if (p_perr) push(EV_PERR, '0, te);
    drive_bit(1'b0);
    for (int k = 0; k < DW; k++) drive_bit(d[k]);
    if (P == 1) drive_bit((^d) ^ bad_par);
    for (int i = 0; i < n; i++) begin
      rx_in    = stop_b;
      read_ack = ack_at_stop && (i == h);
      cycles(1);
    end
    read_ack = 1'b0;
    if (!stop_b) cycles(extra_low);
  endtask

  initial begin
    arst = 1'b0;
    rx_in = 1'b1;
    cycles(3);
    chk("reset_n1", {d0, rdy0, fe0, pe0, ov0, bz0}, 32'h0);
    chk("reset_n4", {d1, rdy1, fe1, pe1, ov1, bz1}, 32'h0);
    arst = 1'b1;
    idle(2);

    // one clock per bit
    sel = 0;
    send(8'hA5, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    chk("a5_data", m_d, 8'hA5);
    chk("a5_ready", m_rdy, 1);
    chk("a5_flags", {m_fe, m_pe, m_ov}, 0);
    ack();
    chk("a5_ack_clears", m_rdy, 0);

    send(8'h11, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send(8'h22, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("b2b_data", m_d, 8'h11);
    chk("b2b_ready_ovr", {m_rdy, m_ov}, 2'b11);
    ack();
    chk("b2b_ack_clears", {m_rdy, m_ov}, 2'b00);

    send(8'h33, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send(8'h22, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    chk("simul_ack_data", m_d, 8'h22);
    chk("simul_ack_ready_ovr", {m_rdy, m_ov}, 2'b10);
    ack();

    // four clocks per bit
    sel = 1;
    idle(2);
    send(8'h3C, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    chk("3c_data", m_d, 8'h3C);
    ack();

    rx_in = 1'b0;
    cycles(1);
    chk("glitch_busy_rise", m_bz, 1);
    rx_in = 1'b1;
    cycles(1);
    chk("glitch_busy_drop", m_bz, 0);
    idle(6);
    chk("glitch_no_word", m_rdy, 0);

    send(8'h00, 1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("break_busy", m_bz, 1);
    chk("break_no_word", {m_rdy, m_fe}, 2'b00);
    idle(2);
    chk("break_exit", m_bz, 0);
    send(8'h01, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    chk("after_break_data", m_d, 8'h01);
    ack();

    // reset in the middle of a frame
    rx_in = 1'b0;
    cycles(4);
    rx_in = 1'b1;
    cycles(8);
    chk("mid_frame_busy", m_bz, 1);
    arst = 1'b0;
    #2;
    chk("mid_reset_async", {m_d, m_rdy, m_fe, m_pe, m_ov, m_bz}, 32'h0);
    cycles(1);
    chk("mid_reset_held", {m_d, m_rdy, m_fe, m_pe, m_ov, m_bz}, 32'h0);
    arst = 1'b1;
    idle(3);
    send(8'h7E, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    chk("7e_data", m_d, 8'h7E);
    ack();

`ifdef RX_PARITY_EN
    send(8'h7E, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    chk("bad_parity_no_word", m_rdy, 0);
`endif

    idle(4);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/receiver_unit.md
# receiver_unit

Serial frame receiver that consumes the single-wire bit stream produced by the transmitter stage and reassembles it into parallel words. It detects the start bit, samples data bits LSB first, checks the stop bit, and presents each good word on a held-valid/acknowledge interface to the downstream consumer. Bad frames and words that arrive while the previous word is still unread are flagged, not delivered.

## Interface
- DATA_WIDTH, 8: data bits per frame.
- CLKS_PER_BIT, 1: clock cycles per serial bit; integer ≥ 1.
- clk  in  1  sole clock; all logic on posedge.
- arst  in  1  asynchronous, active-low reset.
- rx_in  in  1  serial line, synchronous to clk; idles high.
- read_ack  in  1  consumer has taken data_out; single-cycle pulse.
- data_out  out  DATA_WIDTH  last delivered word; held stable while output_ready = 1.
- output_ready  out  1  level; word valid, held until read_ack.
- frame_error  out  1  one-cycle pulse; stop bit sampled low.
- parity_error  out  1  one-cycle pulse; parity mismatch (RX_PARITY_EN only, else tied 0).
- overrun  out  1  sticky; a good frame completed while output_ready = 1.
- busy  out  1  high in every state except IDLE.

## Operation
- Frame: start 0, DATA_WIDTH data bits LSB first, optional parity, stop 1.
- States: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
- IDLE: rx_in = 0 at a clock edge = start edge t0 → START; bit timer cleared.
- START: sample at t0 + H, H = (CLKS_PER_BIT−1)/2 (integer floor). rx_in = 1 → false start, back to IDLE, no flags. rx_in = 0 → DATA. For CLKS_PER_BIT = 1, H = 0 and START is passed in the t0 cycle (IDLE → DATA directly).
- DATA: bit k (0..DATA_WIDTH−1) sampled at t0 + H + (k+1)·CLKS_PER_BIT into a shift register, LSB first; bit counter width ceil(log2(DATA_WIDTH+1)), no wrap beyond DATA_WIDTH−1.
- STOP: sample at t0 + H + (DATA_WIDTH+1+P)·CLKS_PER_BIT, P = 1 with parity else 0.
  - rx_in = 1 and no parity error: if output_ready = 0 → load data_out, output_ready = 1; else discard word, set overrun. → IDLE.
  - rx_in = 0: frame_error pulse, word discarded → BREAK.
- BREAK: wait until rx_in = 1, then → IDLE (prevents a low line being taken as a new start).
- read_ack with output_ready = 1: clears output_ready and overrun next edge. read_ack with output_ready = 0: ignored.
- Simultaneous read_ack and good-frame completion: new word loaded, output_ready stays 1, overrun not set.
- Reset (any time, including mid-frame): state IDLE, data_out = 0, output_ready = 0, frame_error = 0, parity_error = 0, overrun = 0, busy = 0, timers and shift register 0. Partial frame is lost.

## Timing
- All outputs registered.
- CLKS_PER_BIT = 1, DATA_WIDTH = 8: start at cycle t0, data t0+1..t0+8, stop t0+9; output_ready/frame_error visible from t0+10.
- Earliest next start edge accepted: cycle after stop sample (t0+10 at N = 1), so back-to-back frames receive without gap.
- General latency start edge → output_ready: H + (DATA_WIDTH+1+P)·CLKS_PER_BIT + 1 cycles.
- busy rises the cycle after t0, falls the cycle after the stop sample (or after BREAK exit).

## Configuration
- RX_PARITY_EN defined: PARITY state after DATA; one even-parity bit sampled at t0 + H + (DATA_WIDTH+1)·CLKS_PER_BIT; mismatch → parity_error pulse at stop-sample+1, word discarded (stop still checked; both errors may pulse together).
- RX_PARITY_EN undefined: no PARITY state, frame is DATA_WIDTH+2 bits, parity_error constant 0.

## Structure
- Shared package rx_pkg: state enum (IDLE, START, DATA, PARITY, STOP, BREAK), START_BIT = 0, STOP_BIT = 1, line-idle constant.
- One sub-module, rx_bit_timer: counts CLKS_PER_BIT, issues sample strobe at offset H then every CLKS_PER_BIT cycles; cleared on start edge and reset.

## Test plan
- N = 1, send 0xA5 (line 0,1,0,1,0,0,1,0,1,1) → output_ready at t0+10, data_out = 0xA5, no flags; read_ack → output_ready 0.
- N = 4, send 0x3C then glitch rx_in low 1 cycle in idle → 0x3C delivered at t0+H+9·4+1 = t0+38; glitch gives no start, busy drops within 2 cycles.
- Stop bit 0 with line held low 5 cycles → frame_error one pulse, no delivery, stays BREAK until rx_in = 1, then next frame 0x01 received correctly.
- Two frames 0x11, 0x22 back-to-back without read_ack → data_out = 0x11, overrun = 1; read_ack clears both.
- read_ack on the same edge as frame 0x22 completes → data_out = 0x22, output_ready = 1, overrun = 0.
- arst low mid-DATA, release, send 0x7E → all outputs 0 during reset, 0x7E delivered; with RX_PARITY_EN, corrupt parity on 0x7E → parity_error pulse, no delivery.
